// File: rtl/stopwatch_time_counter.sv
// MM:SS BCD time counter for the stopwatch: sub-second tick prescaler, run-mode carry chain,
// and per-unit increment/decrement editing with wrap-around and no cross-unit carry.
module stopwatch_time_counter #(
    parameter int TICKS_PER_SEC = 100,
    parameter int MAX_MIN       = 59
) (
    input  logic                             iClk,
    input  logic                             iRst,
    input  logic                             iTick,
    input  logic                             iRun,
    input  logic                             iEditEn,
    input  logic                             iEditUnit,
    input  logic                             iEditInc,
    input  logic                             iEditDec,
    input  logic                             iClear,
    output logic [3:0]                       oMinTens,
    output logic [3:0]                       oMinOnes,
    output logic [3:0]                       oSecTens,
    output logic [3:0]                       oSecOnes,
    output logic [$clog2(TICKS_PER_SEC)-1:0] oSubSec,
    output logic                             oWrap
);

    localparam int             SW       = $clog2(TICKS_PER_SEC);
    localparam logic [SW-1:0]  SUB_LAST = SW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]     MIN_T    = 4'(MAX_MIN / 10);
    localparam logic [3:0]     MIN_O    = 4'(MAX_MIN % 10);
    localparam logic [3:0]     SEC_T    = 4'd5;
    localparam logic [3:0]     SEC_O    = 4'd9;

    logic [3:0]    r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
    logic [SW-1:0] r_sub_sec;
    logic          r_wrap;

    logic [7:0]    w_min, w_sec, w_min_next, w_sec_next;
    logic [SW-1:0] w_sub_next;
    logic          w_wrap_next;

    // Two-digit BCD +1 / -1 that wraps between 00 and the given top value.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] top_t,
                                           input logic [3:0] top_o);
        if (v == {top_t, top_o})
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [3:0] top_t,
                                           input logic [3:0] top_o);
        if (v == 8'h00)
            return {top_t, top_o};
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign w_min = {r_min_tens, r_min_ones};
    assign w_sec = {r_sec_tens, r_sec_ones};

    always_comb begin
        w_min_next  = w_min;
        w_sec_next  = w_sec;
        w_sub_next  = r_sub_sec;
        w_wrap_next = 1'b0;
        if (iClear) begin
            w_min_next = 8'h00;
            w_sec_next = 8'h00;
            w_sub_next = '0;
        end else if (iEditEn) begin
            // Conflicting inc+dec is treated as no request at all.
            if (iEditInc ^ iEditDec) begin
                w_sub_next = '0;
                case ({iEditUnit, iEditInc})
                    2'b01:   w_min_next = bcd_inc(w_min, MIN_T, MIN_O);
                    2'b00:   w_min_next = bcd_dec(w_min, MIN_T, MIN_O);
                    2'b11:   w_sec_next = bcd_inc(w_sec, SEC_T, SEC_O);
                    default: w_sec_next = bcd_dec(w_sec, SEC_T, SEC_O);
                endcase
            end
        end else if (iRun && iTick) begin
            if (r_sub_sec != SUB_LAST) begin
                w_sub_next = r_sub_sec + SW'(1);
            end else begin
                w_sub_next = '0;
                w_sec_next = bcd_inc(w_sec, SEC_T, SEC_O);
                if (w_sec == {SEC_T, SEC_O}) begin
                    w_min_next  = bcd_inc(w_min, MIN_T, MIN_O);
                    w_wrap_next = (w_min == {MIN_T, MIN_O});
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_min_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_sec_ones <= 4'd0;
            r_sub_sec  <= '0;
            r_wrap     <= 1'b0;
        end else begin
            r_min_tens <= w_min_next[7:4];
            r_min_ones <= w_min_next[3:0];
            r_sec_tens <= w_sec_next[7:4];
            r_sec_ones <= w_sec_next[3:0];
            r_sub_sec  <= w_sub_next;
            r_wrap     <= w_wrap_next;
        end
    end

    assign oMinTens = r_min_tens;
    assign oMinOnes = r_min_ones;
    assign oSecTens = r_sec_tens;
    assign oSecOnes = r_sec_ones;
    assign oSubSec  = r_sub_sec;
    assign oWrap    = r_wrap;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter: directed scenarios then random traffic, checked against
// a model that tracks elapsed time as a plain count of seconds and sub-second ticks.
module tb_stopwatch_time_counter;

    localparam int TPS  = 4;
    localparam int MMAX = 59;
    localparam int SW   = $clog2(TPS);

    logic          iClk = 1'b0;
    logic          iRst, iTick, iRun, iEditEn, iEditUnit, iEditInc, iEditDec, iClear;
    logic [3:0]    oMinTens, oMinOnes, oSecTens, oSecOnes;
    logic [SW-1:0] oSubSec;
    logic          oWrap;

    int n_asserts = 0;
    int n_fail    = 0;

    // Model state: total seconds on the clock face, sub-second ticks, wrap flag.
    int m_secs = 0;
    int m_sub  = 0;
    int m_wrap = 0;

    stopwatch_time_counter #(.TICKS_PER_SEC(TPS), .MAX_MIN(MMAX)) dut (
        .iClk(iClk), .iRst(iRst), .iTick(iTick), .iRun(iRun), .iEditEn(iEditEn),
        .iEditUnit(iEditUnit), .iEditInc(iEditInc), .iEditDec(iEditDec), .iClear(iClear),
        .oMinTens(oMinTens), .oMinOnes(oMinOnes), .oSecTens(oSecTens), .oSecOnes(oSecOnes),
        .oSubSec(oSubSec), .oWrap(oWrap)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic rst, clr, tick, run, en, unit, inc, dec);
        int m, s;
        m_wrap = 0;
        m = m_secs / 60;
        s = m_secs % 60;
        if (rst || clr) begin
            m_secs = 0;
            m_sub  = 0;
        end else if (en) begin
            if (inc != dec) begin
                if (!unit) m = inc ? (m + 1) % (MMAX + 1) : (m + MMAX) % (MMAX + 1);
                else       s = inc ? (s + 1) % 60 : (s + 59) % 60;
                m_secs = m * 60 + s;
                m_sub  = 0;
            end
        end else if (run && tick) begin
            m_sub++;
            if (m_sub == TPS) begin
                m_sub = 0;
                m_secs++;
                if (m_secs == (MMAX + 1) * 60) begin
                    m_secs = 0;
                    m_wrap = 1;
                end
            end
        end
    endtask

    task automatic compare_model(input string tag);
        int m, s;
        m = m_secs / 60;
        s = m_secs % 60;
        $display("[%0t] %s  dut %0d%0d:%0d%0d.%0d wrap=%0d  model %02d:%02d.%0d wrap=%0d",
                 $time, tag, oMinTens, oMinOnes, oSecTens, oSecOnes, oSubSec, oWrap,
                 m, s, m_sub, m_wrap);
        check({tag, ".min_tens"}, int'(oMinTens), m / 10);
        check({tag, ".min_ones"}, int'(oMinOnes), m % 10);
        check({tag, ".sec_tens"}, int'(oSecTens), s / 10);
        check({tag, ".sec_ones"}, int'(oSecOnes), s % 10);
        check({tag, ".sub"},      int'(oSubSec),  m_sub);
        check({tag, ".wrap"},     int'(oWrap),    m_wrap);
    endtask

    // One clock: drive inputs, advance DUT and model together, compare after the edge.
    task automatic step(input string tag, input logic rst, clr, tick, run, en, unit, inc, dec);
        iRst = rst; iClear = clr; iTick = tick; iRun = run;
        iEditEn = en; iEditUnit = unit; iEditInc = inc; iEditDec = dec;
        @(posedge iClk);
        model_update(rst, clr, tick, run, en, unit, inc, dec);
        #1;
        compare_model(tag);
    endtask

    // Fixed expectations written straight from the scenario, independent of the model.
    task automatic expect_face(input string tag, input int mm, input int ss, input int sub,
                               input int wrap);
        check({tag, ".face"}, {int'(oMinTens), int'(oMinOnes), int'(oSecTens), int'(oSecOnes)} == 0 ? 0 :
              int'(oMinTens) * 1000 + int'(oMinOnes) * 100 + int'(oSecTens) * 10 + int'(oSecOnes),
              (mm / 10) * 1000 + (mm % 10) * 100 + (ss / 10) * 10 + ss % 10);
        check({tag, ".fsub"},  int'(oSubSec), sub);
        check({tag, ".fwrap"}, int'(oWrap),   wrap);
    endtask

    initial begin
        iRst = 1'b1; iClear = 1'b0; iTick = 1'b0; iRun = 1'b0;
        iEditEn = 1'b0; iEditUnit = 1'b0; iEditInc = 1'b0; iEditDec = 1'b0;
        //            tag        rst clr tick run en unit inc dec
        step("por0",      1, 0, 0, 0, 0, 0, 0, 0);
        step("por1",      1, 0, 0, 0, 0, 0, 0, 0);
        expect_face("por", 0, 0, 0, 0);

        // Build 12:34 by editing, run a couple of ticks, then reset mid-count.
        for (int i = 0; i < 12; i++) step("ed_min", 0, 0, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 26; i++) step("ed_sec", 0, 0, 0, 0, 1, 1, 0, 1);
        expect_face("at1234", 12, 34, 0, 0);
        step("run_a",     0, 0, 1, 1, 0, 0, 0, 0);
        step("run_b",     0, 0, 1, 1, 0, 0, 0, 0);
        step("rst_a",     1, 0, 1, 1, 0, 0, 0, 0);
        step("rst_b",     1, 0, 1, 1, 0, 0, 0, 0);
        expect_face("rst", 0, 0, 0, 0);

        // Run carry 00:59 -> 01:00 over four ticks.
        step("pre59",     0, 0, 0, 0, 1, 1, 0, 1);
        expect_face("pre59", 0, 59, 0, 0);
        step("carry1",    0, 0, 1, 1, 0, 0, 0, 0);
        check("carry1.sub", int'(oSubSec), 1);
        step("carry2",    0, 0, 1, 1, 0, 0, 0, 0);
        check("carry2.sub", int'(oSubSec), 2);
        step("carry3",    0, 0, 1, 1, 0, 0, 0, 0);
        check("carry3.sub", int'(oSubSec), 3);
        step("carry4",    0, 0, 1, 1, 0, 0, 0, 0);
        expect_face("carry4", 1, 0, 0, 0);

        // Full wrap from 59:59.
        step("clr",       0, 1, 0, 0, 0, 0, 0, 0);
        step("dsec",      0, 0, 0, 0, 1, 1, 0, 1);
        step("dmin",      0, 0, 0, 0, 1, 0, 0, 1);
        expect_face("at5959", 59, 59, 0, 0);
        for (int i = 0; i < 3; i++) step("wrap_pre", 0, 0, 1, 1, 0, 0, 0, 0);
        check("wrap_pre.sub", int'(oSubSec), TPS - 1);
        step("wrap",      0, 0, 1, 1, 0, 0, 0, 0);
        expect_face("wrap", 0, 0, 0, 1);
        step("wrap_post", 0, 0, 0, 1, 0, 0, 0, 0);
        expect_face("wrap_post", 0, 0, 0, 0);

        // Edit wrap in both units.
        step("ew_sdec",   0, 0, 0, 0, 1, 1, 0, 1);
        expect_face("ew_sdec", 0, 59, 0, 0);
        step("ew_mdec",   0, 0, 0, 0, 1, 0, 0, 1);
        expect_face("ew_mdec", 59, 59, 0, 0);
        step("ew_minc",   0, 0, 0, 0, 1, 0, 1, 0);
        expect_face("ew_minc", 0, 59, 0, 0);
        step("ew_sinc",   0, 0, 0, 0, 1, 1, 1, 0);
        expect_face("ew_sinc", 0, 0, 0, 0);

        // Ignore rules: ticks in edit mode, inc+dec together, inc outside edit.
        step("ig_run",    0, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step("ig_tick", 0, 0, 1, 1, 1, 0, 0, 0);
        expect_face("ig_tick", 0, 0, 1, 0);
        step("ig_both",   0, 0, 0, 0, 1, 1, 1, 1);
        expect_face("ig_both", 0, 0, 1, 0);
        step("ig_noen",   0, 0, 0, 0, 0, 0, 1, 0);
        expect_face("ig_noen", 0, 0, 1, 0);

        // Priority: clear beats edit and run tick.
        for (int i = 0; i < 5; i++) step("p_min", 0, 0, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 30; i++) step("p_sec", 0, 0, 0, 0, 1, 1, 0, 1);
        expect_face("at0530", 5, 30, 0, 0);
        step("p_clrinc",  0, 1, 0, 0, 1, 0, 1, 0);
        expect_face("p_clrinc", 0, 0, 0, 0);
        step("p_run",     0, 0, 1, 1, 0, 0, 0, 0);
        step("p_clrtick", 0, 1, 1, 1, 0, 0, 0, 0);
        expect_face("p_clrtick", 0, 0, 0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step("rand",
                 ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
